// File: rtl/pc_fetch_unit_if.sv
// rtl/pc_fetch_unit_if.sv - fetch-stage bundle: imem req/ack, decode handshake, redirect and halt
interface pc_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        br_taken;
    logic [31:0] br_base;
    logic [31:0] br_offset;
    logic        jmp_abs;
    logic [31:0] jmp_target;
    logic        halt;
    logic        halted;

    modport master (
        output imem_req, imem_addr, instr, instr_pc, instr_valid, halted,
        input  imem_ack, imem_rdata, instr_ready, br_taken, br_base, br_offset,
               jmp_abs, jmp_target, halt
    );

    modport slave (
        input  imem_req, imem_addr, instr, instr_pc, instr_valid, halted,
        output imem_ack, imem_rdata, instr_ready, br_taken, br_base, br_offset,
               jmp_abs, jmp_target, halt
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - KGP-RISC instruction fetch: PC, imem req/ack, decode handshake, redirect, halt
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic           clk,
    input  logic           rst,
    pc_fetch_unit_if.master bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2,
        S_HALT = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_instr_pc;
    logic        r_instr_valid;
    logic        r_halted;

    logic        w_redirect;
    logic [31:0] w_redirect_pc;
    logic        w_req;

    assign w_redirect    = bus.jmp_abs | bus.br_taken;
    assign w_redirect_pc = bus.jmp_abs ? bus.jmp_target : (bus.br_base + bus.br_offset);
    assign w_req         = (r_state == S_REQ);

    assign bus.imem_req    = w_req;
    assign bus.imem_addr   = w_req ? r_pc : 32'h0000_0000;
    assign bus.instr       = r_instr;
    assign bus.instr_pc    = r_instr_pc;
    assign bus.instr_valid = r_instr_valid;
    assign bus.halted      = r_halted;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Priority: halt, then the sticky halt state, then redirect, then normal flow.
    always_comb begin
        w_next_state = r_state;
        if (bus.halt) begin
            w_next_state = S_HALT;
        end else if (r_state == S_HALT) begin
            w_next_state = S_HALT;
        end else if (w_redirect) begin
            w_next_state = S_REQ;
        end else begin
            case (r_state)
                S_IDLE:  w_next_state = S_REQ;
                S_REQ:   if (bus.imem_ack)    w_next_state = S_HOLD;
                S_HOLD:  if (bus.instr_ready) w_next_state = S_REQ;
                default: w_next_state = r_state;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc          <= RESET_PC;
            r_instr       <= 32'h0000_0000;
            r_instr_pc    <= 32'h0000_0000;
            r_instr_valid <= 1'b0;
            r_halted      <= 1'b0;
        end else if (bus.halt) begin
            r_instr_valid <= 1'b0;
            r_halted      <= 1'b1;
        end else if (r_state != S_HALT) begin
            if (w_redirect) begin
                // Any ack arriving with a redirect belongs to the wrong path and is dropped.
                r_pc          <= w_redirect_pc;
                r_instr_valid <= 1'b0;
            end else if (r_state == S_REQ && bus.imem_ack) begin
                r_instr       <= bus.imem_rdata;
                r_instr_pc    <= r_pc;
                r_instr_valid <= 1'b1;
                r_pc          <= r_pc + PC_STEP;
            end else if (r_state == S_HOLD && bus.instr_ready) begin
                r_instr_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - directed and randomized checks of pc_fetch_unit against a behavioural model
module tb_pc_fetch_unit;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    pc_fetch_unit_if bus();

    pc_fetch_unit #(.RESET_PC(32'h0000_0000), .PC_STEP(32'd4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: a PC, whether fetching has begun, whether an instruction is held, halt flag.
    logic [31:0] m_pc;
    logic        m_started;
    logic        m_have;
    logic        m_halt;
    logic [31:0] m_instr;
    logic [31:0] m_instr_pc;
    logic        ack_en;

    function automatic logic m_req();
        return m_started && !m_have && !m_halt;
    endfunction

    task automatic model_reset();
        m_pc = 32'h0; m_started = 1'b0; m_have = 1'b0; m_halt = 1'b0;
        m_instr = 32'h0; m_instr_pc = 32'h0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("imem_req",    {31'h0, bus.imem_req},    {31'h0, m_req()});
        chk("imem_addr",   bus.imem_addr,            m_req() ? m_pc : 32'h0);
        chk("instr_valid", {31'h0, bus.instr_valid}, {31'h0, m_have});
        chk("halted",      {31'h0, bus.halted},      {31'h0, m_halt});
        chk("instr",       bus.instr,                m_instr);
        chk("instr_pc",    bus.instr_pc,             m_instr_pc);
    endtask

    task automatic clr();
        bus.br_taken = 1'b0; bus.jmp_abs = 1'b0; bus.halt = 1'b0;
        bus.br_base = 32'h0; bus.br_offset = 32'h0; bus.jmp_target = 32'h0;
    endtask

    // One clock: present ack for the modelled request, advance the model, take the edge, check.
    task automatic cycle();
        logic ack;
        ack = ack_en && m_req();
        bus.imem_ack   = ack;
        bus.imem_rdata = ack ? (m_pc ^ 32'hA5A5_0000) : 32'hDEAD_BEEF;
        if (bus.halt) begin
            m_halt = 1'b1;
            m_have = 1'b0;
        end else if (!m_halt) begin
            if (bus.jmp_abs || bus.br_taken) begin
                m_pc   = bus.jmp_abs ? bus.jmp_target : bus.br_base + bus.br_offset;
                m_have = 1'b0;
            end else if (ack) begin
                m_instr    = bus.imem_rdata;
                m_instr_pc = m_pc;
                m_have     = 1'b1;
                m_pc       = m_pc + 32'd4;
            end else if (m_have && bus.instr_ready) begin
                m_have = 1'b0;
            end
            m_started = 1'b1;
        end
        @(posedge clk);
        #1;
        check_all();
        clr();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #2;
        model_reset();
        check_all();
        rst = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        ack_en = 1'b0;
        bus.instr_ready = 1'b0;
        bus.imem_ack = 1'b0;
        bus.imem_rdata = 32'h0;
        clr();
        model_reset();
        repeat (2) @(posedge clk);
        #1;

        // Streaming fetch with zero-wait memory and an always-ready decoder.
        do_reset();
        chk("idle_no_req", {31'h0, bus.imem_req}, 32'h0);
        ack_en = 1'b1;
        bus.instr_ready = 1'b1;
        cycle();
        chk("first_req_addr0", bus.imem_addr, 32'h0);
        chk("first_req", {31'h0, bus.imem_req}, 32'h1);
        for (int i = 0; i < 8; i++) cycle();
        chk("seq_instr_pc_C", bus.instr_pc, 32'h0000_000C);
        chk("seq_instr_C", bus.instr, 32'hA5A5_000C);

        // Backpressure: hold the first instruction for five cycles.
        do_reset();
        bus.instr_ready = 1'b0;
        cycle();
        cycle();
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("bp_hold_pc", bus.instr_pc, 32'h0);
        end
        bus.instr_ready = 1'b1;
        cycle();
        chk("bp_resume_addr", bus.imem_addr, 32'h4);
        bus.instr_ready = 1'b0;

        // Backward branch from S_HOLD.
        cycle();
        bus.br_taken = 1'b1; bus.br_base = 32'h20; bus.br_offset = 32'hFFFF_FFF8;
        cycle();
        chk("br_back_addr", bus.imem_addr, 32'h18);
        chk("br_back_flush", {31'h0, bus.instr_valid}, 32'h0);
        cycle();
        bus.br_taken = 1'b1; bus.br_base = 32'h20; bus.br_offset = 32'h10;
        cycle();
        chk("br_fwd_addr", bus.imem_addr, 32'h30);

        // Jump beats branch; ack in the same cycle is discarded.
        bus.br_taken = 1'b1; bus.br_base = 32'h20; bus.br_offset = 32'h10;
        bus.jmp_abs = 1'b1; bus.jmp_target = 32'h100;
        cycle();
        chk("jmp_wins_addr", bus.imem_addr, 32'h100);
        chk("redir_ack_drop", {31'h0, bus.instr_valid}, 32'h0);

        // PC wraps past the top of the address space.
        bus.jmp_abs = 1'b1; bus.jmp_target = 32'hFFFF_FFFC;
        cycle();
        cycle();
        chk("wrap_instr_pc", bus.instr_pc, 32'hFFFF_FFFC);
        bus.instr_ready = 1'b1;
        cycle();
        chk("wrap_addr", bus.imem_addr, 32'h0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            ack_en          = ($urandom_range(0, 3) != 0);
            bus.instr_ready = ($urandom_range(0, 2) != 0);
            bus.br_taken    = ($urandom_range(0, 9) == 0);
            bus.jmp_abs     = ($urandom_range(0, 14) == 0);
            bus.br_base     = $urandom;
            bus.br_offset   = $urandom;
            bus.jmp_target  = $urandom;
            cycle();
        end

        // Halt in S_REQ with a coincident ack and branch.
        ack_en = 1'b1;
        bus.instr_ready = 1'b1;
        bus.jmp_abs = 1'b1; bus.jmp_target = 32'h40;
        cycle();
        chk("pre_halt_addr", bus.imem_addr, 32'h40);
        bus.halt = 1'b1; bus.br_taken = 1'b1; bus.br_base = 32'h80; bus.br_offset = 32'h4;
        cycle();
        chk("halt_halted", {31'h0, bus.halted}, 32'h1);
        chk("halt_no_req", {31'h0, bus.imem_req}, 32'h0);
        chk("halt_no_valid", {31'h0, bus.instr_valid}, 32'h0);
        for (int i = 0; i < 6; i++) begin
            bus.br_taken = ($urandom_range(0, 1) == 1);
            bus.jmp_abs  = ($urandom_range(0, 1) == 1);
            bus.jmp_target = $urandom;
            cycle();
        end
        chk("halt_sticky", {31'h0, bus.halted}, 32'h1);

        // Asynchronous reset between edges while holding an instruction.
        do_reset();
        bus.instr_ready = 1'b0;
        cycle();
        cycle();
        cycle();
        chk("pre_rst_valid", {31'h0, bus.instr_valid}, 32'h1);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #2;
        check_all();
        rst = 1'b0;
        bus.instr_ready = 1'b1;
        cycle();
        chk("restart_addr", bus.imem_addr, 32'h0);
        for (int i = 0; i < 6; i++) cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
